// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI receive-path constants
package spi_pkg;
  localparam int BYTE_W        = 8;
  localparam int RX_FIFO_DEPTH = 16;
endpackage

// File: rtl/spi_fifo_mem.sv
// rtl/spi_fifo_mem.sv - DEPTH x WIDTH storage, sync write, async read, no reset
module spi_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/spi_rx_fifo.sv
// rtl/spi_rx_fifo.sv - SPI receive byte FIFO with valid/ready output and sticky overflow
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int WIDTH = BYTE_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           byte_recv,
  input  logic                       valid,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out_byte,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]    wp, rp;
  logic [WIDTH-1:0] rdata;
  logic             push, pop, drop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop  = !empty && out_ready;
  assign push = valid && (!full || pop);
  assign drop = valid && full && !pop;

  spi_fifo_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wp),
    .wdata (byte_recv),
    .raddr (rp),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is never reset, so mask the head while empty.
  assign out_valid = !empty;
  assign out_byte  = empty ? '0 : rdata;
endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb/tb_spi_rx_fifo.sv - scoreboard testbench for spi_rx_fifo
module tb_spi_rx_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_recv;
  logic       valid;
  logic       flush;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       full, empty, overflow;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_pop;

  spi_rx_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .byte_recv (byte_recv),
    .valid     (valid),
    .flush     (flush),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    valid     = 1'b1;
    byte_recv = b;
    if (accepted) exp_q.push_back(b);
    tick();
    valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!empty && n < 40) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check({name, "_empty"}, empty, 1);
    check({name, "_sb_left"}, exp_q.size(), 0);
  endtask

  // Monitor: every accepted head byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got %0h expected none", out_byte);
      end else begin
        if (out_byte !== exp_q[0]) begin
          fails++;
          $display("FAIL pop_data: got %0h expected %0h", out_byte, exp_q[0]);
        end
        last_pop = out_byte;
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; flush = 1'b0; out_ready = 1'b0; byte_recv = 8'h00;
    repeat (2) tick();
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 8'h00);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();
    check("idle_empty", empty, 1);

    // Three back-to-back bytes, then stall
    push_byte(8'hA5, 1);
    push_byte(8'h3C, 1);
    push_byte(8'h7E, 1);
    check("stall_count", count, 3);
    for (int i = 0; i < 5; i++) begin
      check("stall_head", out_byte, 8'hA5);
      check("stall_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("three_empty", empty, 1);
    check("three_sb_left", exp_q.size(), 0);

    // Fill to full and overflow
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
    check("fill_full", full, 1);
    check("fill_ovf_before", overflow, 0);
    push_byte(8'hFF, 0);
    check("drop_full", full, 1);
    check("drop_overflow", overflow, 1);
    check("drop_count", count, 16);
    drain("drain16");
    check("ovf_sticky", overflow, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i), 1);
    check("full2", full, 1);
    out_ready = 1'b1;
    push_byte(8'h55, 1);
    out_ready = 1'b0;
    check("pp_count", count, 16);
    check("pp_overflow", overflow, 0);
    check("pp_full", full, 1);
    drain("drain_pp");
    check("pp_last", last_pop, 8'h55);

    // Wrap-around stream; push rate 2/3, pop rate 1/2, never reaches full
    begin
      int sent;
      int cyc;
      sent = 0;
      cyc = 0;
      while (sent < 40) begin
        out_ready = cyc[0];
        if (cyc % 3 != 2) begin
          valid = 1'b1;
          byte_recv = 8'(8'h40 + sent);
          exp_q.push_back(8'(8'h40 + sent));
          sent++;
        end else begin
          valid = 1'b0;
        end
        tick();
        cyc++;
      end
      valid = 1'b0;
      out_ready = 1'b0;
    end
    check("wrap_overflow", overflow, 0);
    drain("drain_wrap");

    // Flush with a concurrent strobe at count 5
    for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i), 1);
    check("pre_flush_count", count, 5);
    flush = 1'b1;
    valid = 1'b1;
    byte_recv = 8'h99;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    exp_q.delete();
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_overflow", overflow, 0);
    check("flush_out_byte", out_byte, 8'h00);
    tick();
    check("flush_strobe_dropped", count, 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) push_byte(8'(8'hE0 + i), 1);
    check("pre_rst_count", count, 4);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_byte", out_byte, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_empty", empty, 1);
    check("post_rst_overflow", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_rx_fifo.md
# spi_rx_fifo

Receive-side byte buffer between the SPI byte deserializer (`spi_module`) and the command assembler (`cmd_in`). It captures every single-cycle `valid` pulse with its `byte_recv` value. It presents bytes downstream in arrival order over a valid/ready handshake, so command parsing can stall without losing SPI traffic. It also reports occupancy and a sticky overflow flag for bring-up debug.

## Interface
Parameters:
- `DEPTH`, 16: number of byte entries. Must be a power of two and at least 2.
- `WIDTH`, 8: entry width in bits.

Ports:
- `clk`, in, 1: system clock (CLOCK_50 domain).
- `rst`, in, 1: reset. Asynchronous assert, active-high.
- `byte_recv`, in, WIDTH: byte from the SPI deserializer.
- `valid`, in, 1: one-cycle strobe. Qualifies `byte_recv`.
- `flush`, in, 1: synchronous clear of contents and flags.
- `out_byte`, out, WIDTH: head-of-queue byte.
- `out_valid`, out, 1: `out_byte` is meaningful.
- `out_ready`, in, 1: consumer accepts the head this cycle.
- `count`, out, $clog2(DEPTH+1): number of stored entries.
- `full`, out, 1: `count == DEPTH`.
- `empty`, out, 1: `count == 0`.
- `overflow`, out, 1: sticky; a byte was dropped.

## Operation
- Storage is a circular buffer with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits.
  - Both pointers wrap naturally from DEPTH-1 to 0.
  - `count` is tracked explicitly. Full and empty are never inferred from pointer equality alone.
- Push: occurs when `valid` is high and the FIFO can accept. The FIFO can accept when `!full`, or when `full` and a pop occurs in the same cycle.
  - On push, `byte_recv` is written at `wp` and `wp` increments.
- Drop: when `valid` is high, `full` is high, and no pop occurs, the byte is discarded.
  - `overflow` sets and stays set until `flush` or `rst`.
  - `count` and pointers are unchanged.
- Pop: occurs when `out_valid` and `out_ready` are both high. `rp` increments.
- Count update:
  - Push only: `count` increments.
  - Pop only: `count` decrements.
  - Push and pop together: `count` is unchanged.
- `out_valid` equals `!empty`.
- `out_byte` equals the entry at `rp` when not empty, and `{WIDTH{1'b0}}` when empty.
- `out_byte` must not change while `out_valid && !out_ready`.
- `out_ready` asserted while empty has no effect.
- `flush` has priority over push and pop in the same cycle.
  - It clears `wp`, `rp`, `count`, and `overflow`.
  - A `valid` strobe in the flush cycle is discarded and does not set `overflow`.
- Storage contents are not reset. Only pointers, count, and flags are reset.

## Timing
- Reset (async assert, effective immediately): `count`=0, `empty`=1, `full`=0, `out_valid`=0, `out_byte`=0, `overflow`=0, `wp`=`rp`=0.
- Reset mid-stream discards all queued bytes.
- Write-to-read latency is 1 cycle. A byte pushed at edge N is visible on `out_byte`/`out_valid` after edge N. There is no same-cycle bypass when empty.
- `count`, `full`, `empty`, and `overflow` are registered and reflect the previous edge's push, pop, flush, and drop.
- Sustained throughput is 1 push and 1 pop per cycle, at every occupancy including full.
- `out_byte`, `out_valid`, `full`, `empty`, and `count` are derived only from registers and storage. `out_ready` has no combinational path to any output.
- `valid` is at most 1 cycle wide per byte. Back-to-back `valid` pulses on consecutive cycles must be accepted.

## Structure
- Shared package `spi_pkg`:
  - `BYTE_W` = 8, used as the `WIDTH` default.
  - `RX_FIFO_DEPTH` = 16, used as the top-level instantiation value.
- Sub-module `spi_fifo_mem`: a DEPTH x WIDTH storage array.
  - One synchronous write port (`we`, `waddr`, `wdata`).
  - One asynchronous read port (`raddr`, `rdata`).
  - No reset. Maps to distributed RAM or registers.
- Top level holds pointers, count, flag logic, and output masking.
- Planned placement: between `spi_module.byte_recv`/`valid` and `cmd_in`. `cmd_in` gains an `out_ready` backpressure input.

## Test plan
- Reset then idle: `empty`=1, `count`=0, `out_valid`=0, `out_byte`=8'h00.
- Push 8'hA5, 8'h3C, 8'h7E on consecutive cycles with `out_ready`=0:
  - `count`=3 and `out_byte`=8'hA5, held stable over 5 stall cycles.
  - Then raise `out_ready` for 3 cycles: outputs A5, 3C, 7E in order, then `empty`=1.
- Fill 16 bytes 8'h00..8'h0F, then push 8'hFF:
  - `full`=1, `overflow`=1, `count`=16, and 8'hFF is dropped.
  - Drain yields 8'h00..8'h0F.
  - `overflow` stays 1 after draining, until `flush`.
- While full, push 8'h55 with `out_ready`=1 in the same cycle:
  - `count` stays 16, `overflow` stays 0, and the last drained byte is 8'h55.
- Wrap-around: stream 40 bytes (incrementing pattern) with `out_ready` toggling every other cycle. The output sequence matches the input with no loss or duplication.
- Flush and `valid` in the same cycle at `count`=5: next cycle `count`=0, `empty`=1, `overflow`=0. Async `rst` mid-stream gives the same result.
